alu_arbiter: RTL and testbench

//  Shares one alu datapath instance between NREQ requesters (e.g. execute stage, branch/address unit).

---
 rtl/alu_pkg.sv | 21 ++
 rtl/alu.sv | 35 +++
 rtl/alu_arbiter.sv | 134 +++++++++++++
 tb/tb_alu_arbiter.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared ALU definitions: func code encoding, func width and default datapath width.
package alu_pkg;

    localparam int ALU_FUNC_W = 4;
    localparam int ALU_XLEN   = 32;

    typedef enum logic [ALU_FUNC_W-1:0] {
        ALU_ADD   = 4'd0,
        ALU_SUB   = 4'd1,
        ALU_SLL   = 4'd2,
        ALU_SLT   = 4'd3,
        ALU_SLTU  = 4'd4,
        ALU_XOR   = 4'd5,
        ALU_SRL   = 4'd6,
        ALU_SRA   = 4'd7,
        ALU_OR    = 4'd8,
        ALU_AND   = 4'd9,
        ALU_PASSB = 4'd10
    } alu_func_e;

endpackage

// File: rtl/alu.sv
// Combinational ALU datapath; unknown func codes produce zero.
module alu
    import alu_pkg::*;
#(
    parameter int XLEN = ALU_XLEN
) (
    input  logic [ALU_FUNC_W-1:0] func,
    input  logic [XLEN-1:0]       a,
    input  logic [XLEN-1:0]       b,
    output logic [XLEN-1:0]       y
);

    logic [4:0] shamt;

    assign shamt = b[4:0];

    always_comb begin
        y = '0;
        case (func)
            ALU_ADD:   y = a + b;
            ALU_SUB:   y = a - b;
            ALU_SLL:   y = a << shamt;
            ALU_SLT:   y = {{(XLEN-1){1'b0}}, $signed(a) < $signed(b)};
            ALU_SLTU:  y = {{(XLEN-1){1'b0}}, a < b};
            ALU_XOR:   y = a ^ b;
            ALU_SRL:   y = a >> shamt;
            ALU_SRA:   y = $signed(a) >>> shamt;
            ALU_OR:    y = a | b;
            ALU_AND:   y = a & b;
            ALU_PASSB: y = b;
            default:   y = '0;
        endcase
    end

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin sharing of one alu between NREQ requesters with a single registered response slot.
// Optional performance counters enabled by defining ALU_ARB_PERF_EN.
module alu_arbiter
    import alu_pkg::*;
#(
    parameter int XLEN = ALU_XLEN,
    parameter int NREQ = 2,
    parameter int IDW  = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NREQ-1:0]            req_valid,
    output logic [NREQ-1:0]            req_ready,
    input  logic [ALU_FUNC_W*NREQ-1:0] req_func,
    input  logic [XLEN*NREQ-1:0]       req_a,
    input  logic [XLEN*NREQ-1:0]       req_b,
    output logic [NREQ-1:0]            rsp_valid,
    input  logic [NREQ-1:0]            rsp_ready,
    output logic [IDW-1:0]             rsp_id,
    output logic [XLEN-1:0]            rsp_data,
    output logic                       rsp_eq,
    output logic                       rsp_lt,
    output logic                       rsp_ltu,
    output logic [32*NREQ-1:0]         perf_grant_cnt,
    output logic [32*NREQ-1:0]         perf_stall_cnt
);

    localparam logic [0:0] ST_EMPTY = 1'b0;
    localparam logic [0:0] ST_HOLD  = 1'b1;

    logic [0:0]            state;
    logic [IDW-1:0]        rr_ptr;
    logic                  slot_free;
    logic                  grant_vld;
    logic [IDW-1:0]        grant_id;
    logic                  accept;
    logic [ALU_FUNC_W-1:0] f_sel;
    logic [XLEN-1:0]       a_sel;
    logic [XLEN-1:0]       b_sel;
    logic [XLEN-1:0]       alu_y;

    // The owner's rsp_valid is implied by HOLD, so only its rsp_ready matters here.
    assign slot_free = (state == ST_EMPTY) || rsp_ready[rsp_id];

    always_comb begin
        logic [IDW-1:0] idx;
        grant_vld = 1'b0;
        grant_id  = '0;
        idx       = '0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            idx = IDW'((int'(rr_ptr) + int'(k)) % NREQ);
            if (!grant_vld && req_valid[idx]) begin
                grant_vld = 1'b1;
                grant_id  = idx;
            end
        end
    end

    assign accept    = grant_vld && slot_free;
    assign req_ready = accept ? (NREQ'(1) << grant_id) : '0;
    assign rsp_valid = (state == ST_HOLD) ? (NREQ'(1) << rsp_id) : '0;

    always_comb begin
        f_sel = '0;
        a_sel = '0;
        b_sel = '0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            if (IDW'(k) == grant_id) begin
                f_sel = req_func[k*ALU_FUNC_W +: ALU_FUNC_W];
                a_sel = req_a[k*XLEN +: XLEN];
                b_sel = req_b[k*XLEN +: XLEN];
            end
        end
    end

    alu #(
        .XLEN(XLEN)
    ) u_alu (
        .func(f_sel),
        .a   (a_sel),
        .b   (b_sel),
        .y   (alu_y)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_EMPTY;
            rsp_id   <= '0;
            rsp_data <= '0;
            rsp_eq   <= 1'b0;
            rsp_lt   <= 1'b0;
            rsp_ltu  <= 1'b0;
            rr_ptr   <= '0;
        end else if (accept) begin
            state    <= ST_HOLD;
            rsp_id   <= grant_id;
            rsp_data <= alu_y;
            rsp_eq   <= (a_sel == b_sel);
            rsp_lt   <= ($signed(a_sel) < $signed(b_sel));
            rsp_ltu  <= (a_sel < b_sel);
            rr_ptr   <= (grant_id == IDW'(NREQ - 1)) ? '0 : grant_id + 1'b1;
        end else if ((state == ST_HOLD) && rsp_ready[rsp_id]) begin
            state <= ST_EMPTY;
        end
    end

`ifdef ALU_ARB_PERF_EN
    logic [NREQ-1:0][31:0] grant_cnt;
    logic [NREQ-1:0][31:0] stall_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            grant_cnt <= '0;
            stall_cnt <= '0;
        end else begin
            for (int unsigned k = 0; k < NREQ; k++) begin
                if (req_valid[k] && req_ready[k] && (grant_cnt[k] != '1)) begin
                    grant_cnt[k] <= grant_cnt[k] + 32'd1;
                end
                if (req_valid[k] && !req_ready[k] && (stall_cnt[k] != '1)) begin
                    stall_cnt[k] <= stall_cnt[k] + 32'd1;
                end
            end
        end
    end

    assign perf_grant_cnt = grant_cnt;
    assign perf_stall_cnt = stall_cnt;
`else
    assign perf_grant_cnt = '0;
    assign perf_stall_cnt = '0;
`endif

endmodule

// File: tb/tb_alu_arbiter.sv
// Scoreboard bench for alu_arbiter: directed vectors queued per requester, checked by a response monitor.
module tb_alu_arbiter;

    localparam int XLEN = 32;
    localparam int NREQ = 2;
    localparam int IDW  = 1;

    typedef struct packed {
        logic [3:0]  f;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] y;
        logic        eq;
        logic        lt;
        logic        ltu;
    } vec_t;

    logic               clk = 1'b0;
    logic               rst;
    logic [NREQ-1:0]    req_valid;
    logic [NREQ-1:0]    req_ready;
    logic [4*NREQ-1:0]  req_func;
    logic [XLEN*NREQ-1:0] req_a;
    logic [XLEN*NREQ-1:0] req_b;
    logic [NREQ-1:0]    rsp_valid;
    logic [NREQ-1:0]    rsp_ready;
    logic [IDW-1:0]     rsp_id;
    logic [XLEN-1:0]    rsp_data;
    logic               rsp_eq;
    logic               rsp_lt;
    logic               rsp_ltu;
    logic [32*NREQ-1:0] perf_grant_cnt;
    logic [32*NREQ-1:0] perf_stall_cnt;

    int total = 0;
    int bad   = 0;
    vec_t q0[$];
    vec_t q1[$];
    vec_t mon_e;

    alu_arbiter #(
        .XLEN(XLEN),
        .NREQ(NREQ),
        .IDW (IDW)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_func      (req_func),
        .req_a         (req_a),
        .req_b         (req_b),
        .rsp_valid     (rsp_valid),
        .rsp_ready     (rsp_ready),
        .rsp_id        (rsp_id),
        .rsp_data      (rsp_data),
        .rsp_eq        (rsp_eq),
        .rsp_lt        (rsp_lt),
        .rsp_ltu       (rsp_ltu),
        .perf_grant_cnt(perf_grant_cnt),
        .perf_stall_cnt(perf_stall_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic set_req(input int i, input vec_t v);
        req_func[4*i +: 4]    = v.f;
        req_a[XLEN*i +: XLEN] = v.a;
        req_b[XLEN*i +: XLEN] = v.b;
    endtask

    task automatic push_exp(input int i, input vec_t v);
        if (i == 0) q0.push_back(v);
        else        q1.push_back(v);
    endtask

    // Present one request from requester i and hold it until accepted (bounded wait).
    task automatic issue(input int i, input vec_t v, input bit push, output int waited);
        @(posedge clk); #1;
        set_req(i, v);
        if (push) push_exp(i, v);
        req_valid[i] = 1'b1;
        waited = 0;
        do begin
            @(negedge clk);
            waited++;
        end while (!req_ready[i] && waited < 50);
        if (!req_ready[i]) check("issue_timeout", 64'(waited), 64'd0);
        @(posedge clk); #1;
        req_valid[i] = 1'b0;
    endtask

    // Response monitor: every delivered result is matched against the owner's queue.
    always @(negedge clk) begin
        if (!rst && rsp_valid != '0) begin
            check("rsp_onehot", 64'(rsp_valid), 64'(2'b01 << rsp_id));
            if (rsp_ready[rsp_id]) begin
                if ((rsp_id == 0 && q0.size() == 0) || (rsp_id == 1 && q1.size() == 0)) begin
                    check("rsp_unexpected", 64'(rsp_id), 64'hFF);
                end else begin
                    mon_e = (rsp_id == 0) ? q0.pop_front() : q1.pop_front();
                    check("rsp_data", 64'(rsp_data), 64'(mon_e.y));
                    check("rsp_eq",   64'(rsp_eq),   64'(mon_e.eq));
                    check("rsp_lt",   64'(rsp_lt),   64'(mon_e.lt));
                    check("rsp_ltu",  64'(rsp_ltu),  64'(mon_e.ltu));
                end
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // func, A, B, expected result, eq, lt, ltu
        vec_t alt0[4];
        vec_t alt1[4];
        vec_t v;
        int   w;
        int   k0, k1;
        logic [31:0] s0, s1;

        alt0[0] = '{4'd1, 32'd10,    32'd3,   32'd7,     1'b0, 1'b0, 1'b0};
        alt0[1] = '{4'd5, 32'hF0,    32'h0F,  32'hFF,    1'b0, 1'b0, 1'b0};
        alt0[2] = '{4'd8, 32'h100,   32'h1,   32'h101,   1'b0, 1'b0, 1'b0};
        alt0[3] = '{4'd9, 32'hFF,    32'h0F,  32'h0F,    1'b0, 1'b0, 1'b0};
        alt1[0] = '{4'd2, 32'd1,     32'd4,   32'h10,    1'b0, 1'b1, 1'b1};
        alt1[1] = '{4'd6, 32'h80,    32'd3,   32'h10,    1'b0, 1'b0, 1'b0};
        alt1[2] = '{4'd10, 32'd5,    32'd9,   32'd9,     1'b0, 1'b1, 1'b1};
        alt1[3] = '{4'd0, 32'hFFFF_FFFF, 32'd1, 32'd0,   1'b0, 1'b1, 1'b0};

        rst       = 1'b1;
        req_valid = '0;
        req_func  = '0;
        req_a     = '0;
        req_b     = '0;
        rsp_ready = 2'b11;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("reset_rsp_valid", 64'(rsp_valid), 64'd0);
        check("reset_rsp_data",  64'(rsp_data),  64'd0);
        check("reset_rsp_id",    64'(rsp_id),    64'd0);
        check("reset_flags",     64'({rsp_eq, rsp_lt, rsp_ltu}), 64'd0);
        check("reset_req_ready", 64'(req_ready), 64'd0);
        check("reset_perf",      {perf_grant_cnt[31:0], perf_stall_cnt[31:0]}, 64'd0);

        // Lone requester 0: ADD 5+7, one-cycle latency.
        v = '{4'd0, 32'd5, 32'd7, 32'd12, 1'b0, 1'b1, 1'b1};
        issue(0, v, 1'b1, w);
        check("add_grant_wait", 64'(w), 64'd1);
        @(negedge clk);
        check("add_rsp_valid", 64'(rsp_valid), 64'b01);
        check("add_rsp_id",    64'(rsp_id),    64'd0);

        // Both requesters valid every cycle; rr_ptr is 1, so grants run 1,0,1,0...
        for (int i = 0; i < 4; i++) begin
            push_exp(0, alt0[i]);
            push_exp(1, alt1[i]);
        end
        k0 = 0;
        k1 = 0;
        @(posedge clk); #1;
        set_req(0, alt0[0]);
        set_req(1, alt1[0]);
        req_valid = 2'b11;
        for (int cyc = 0; cyc < 8; cyc++) begin
            @(negedge clk);
            check("alt_req_ready", 64'(req_ready), (cyc % 2 == 0) ? 64'b10 : 64'b01);
            if (cyc > 0) check("alt_no_bubble", 64'(rsp_valid), (cyc % 2 == 0) ? 64'b01 : 64'b10);
            @(posedge clk); #1;
            if (cyc % 2 == 0) begin
                k1++;
                if (k1 < 4) set_req(1, alt1[k1]);
                else        req_valid[1] = 1'b0;
            end else begin
                k0++;
                if (k0 < 4) set_req(0, alt0[k0]);
                else        req_valid[0] = 1'b0;
            end
        end

        // Backpressure on requester 1 while requester 0 waits.
        s0 = perf_stall_cnt[31:0];
        s1 = perf_stall_cnt[63:32];
        @(posedge clk); #1;
        v = '{4'd7, 32'h8000_0000, 32'd4, 32'hF800_0000, 1'b0, 1'b1, 1'b0};
        set_req(1, v);
        push_exp(1, v);
        v = '{4'd0, 32'd1, 32'd1, 32'd2, 1'b1, 1'b0, 1'b0};
        set_req(0, v);
        push_exp(0, v);
        rsp_ready = 2'b01;
        req_valid = 2'b11;
        @(negedge clk);
        check("sra_grant", 64'(req_ready), 64'b10);
        @(posedge clk); #1;
        req_valid[1] = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check("stall_rsp_valid", 64'(rsp_valid), 64'b10);
            check("stall_rsp_data",  64'(rsp_data),  64'hF800_0000);
            check("stall_req_ready", 64'(req_ready), 64'b00);
            @(posedge clk); #1;
        end
        rsp_ready = 2'b11;
        @(negedge clk);
        check("drain_b2b_grant", 64'(req_ready), 64'b01);
        @(posedge clk); #1;
        req_valid[0] = 1'b0;
        @(negedge clk);
`ifdef ALU_ARB_PERF_EN
        check("perf_stall0_delta", 64'(perf_stall_cnt[31:0] - s0), 64'd4);
        check("perf_stall1_delta", 64'(perf_stall_cnt[63:32] - s1), 64'd0);
`else
        check("perf_stall_tied", 64'(perf_stall_cnt), 64'd0);
`endif

        // SLT / SLTU on the same operands from requester 0 (rr_ptr is 1 here).
        v = '{4'd3, 32'hFFFF_FFFF, 32'd1, 32'd1, 1'b0, 1'b1, 1'b0};
        issue(0, v, 1'b1, w);
        check("slt_grant_wait", 64'(w), 64'd1);
        v = '{4'd4, 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b0, 1'b1, 1'b0};
        issue(0, v, 1'b1, w);

        // Unused func code yields zero, flags still computed.
        v = '{4'd15, 32'd3, 32'd3, 32'd0, 1'b1, 1'b0, 1'b0};
        issue(0, v, 1'b1, w);

        // Reset while holding an undrained result: it must be dropped.
        @(posedge clk); #1;
        rsp_ready = 2'b00;
        v = '{4'd0, 32'd2, 32'd2, 32'd4, 1'b1, 1'b0, 1'b0};
        issue(0, v, 1'b0, w);
        @(negedge clk);
        check("midhold_rsp_valid", 64'(rsp_valid), 64'b01);
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        check("post_rst_rsp_valid", 64'(rsp_valid), 64'd0);
        check("post_rst_rsp_data",  64'(rsp_data),  64'd0);
        check("post_rst_grant_cnt", 64'(perf_grant_cnt), 64'd0);

        // rr_ptr back at 0: with both valid requester 0 wins.
        @(posedge clk); #1;
        rsp_ready = 2'b11;
        v = '{4'd0, 32'd1, 32'd2, 32'd3, 1'b0, 1'b1, 1'b1};
        set_req(0, v);
        push_exp(0, v);
        v = '{4'd0, 32'd3, 32'd3, 32'd6, 1'b1, 1'b0, 1'b0};
        set_req(1, v);
        push_exp(1, v);
        req_valid = 2'b11;
        @(negedge clk);
        check("rst_rrptr_grant", 64'(req_ready), 64'b01);
        @(posedge clk); #1;
        req_valid[0] = 1'b0;
        @(negedge clk);
        check("rst_second_grant", 64'(req_ready), 64'b10);
        @(posedge clk); #1;
        req_valid[1] = 1'b0;

        for (int n = 1; n <= 9; n++) begin
            v = '{4'd0, 32'(n), 32'd0, 32'(n), 1'b0, 1'b0, 1'b0};
            issue(0, v, 1'b1, w);
        end
        @(negedge clk);
`ifdef ALU_ARB_PERF_EN
        check("perf_grant0", 64'(perf_grant_cnt[31:0]),  64'd10);
        check("perf_grant1", 64'(perf_grant_cnt[63:32]), 64'd1);
`else
        check("perf_grant_tied", 64'(perf_grant_cnt), 64'd0);
`endif

        repeat (3) @(negedge clk);
        check("q0_drained", 64'(q0.size()), 64'd0);
        check("q1_drained", 64'(q1.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
